// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the pipeline hazard unit.
//   fwd_sel_e : operand source select driven on ForwardAE/ForwardBE
//   REG_PC    : register address that never takes part in a dependency match
//   CNT_W     : width of the stall/flush event counters
//   tag_match : address compare that treats the PC register as never matching
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [3:0] REG_PC = 4'hF;
  localparam int         CNT_W  = 16;

  // r15 reads come from the PC path, so a dependency on it is never real.
  function automatic logic tag_match(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && (a != REG_PC);
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter -- up-counter that sticks at all-ones.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear
//   inc   : add one this cycle
//   count : current value, saturates at 2**width-1
module hazard_sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] CNT_MAX = '1;
  localparam logic [width-1:0] CNT_ONE = {{(width-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- stall, flush and forwarding control for a 5-stage pipeline.
//   clk, reset                    : clock and synchronous active-high reset
//   Ra1D, Ra2D, WA3D              : decode-stage source/destination addresses
//   RegWriteE/M/W, MemtoRegE      : per-stage write enables, execute load flag
//   PCSrcD/E/M/W, BranchTakenE    : pending PC writes and taken branch
//   StallF, StallD, FlushD, FlushE: pipeline register control
//   ForwardAE, ForwardBE          : execute operand source select
//   StallCount, FlushCount        : saturating counts of StallD / FlushE cycles
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding with
// load-use stalls only; without it forwarding is off and any RAW dependency
// on E or M stalls decode.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Ra1D,
  input  logic [3:0]       Ra2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [3:0] Ra1E, Ra2E, WA3E, WA3M, WA3W;
  logic       data_stall;
  logic       pc_wr_pending;

  // Decode -> execute -> memory -> writeback address tags
  always_ff @(posedge clk) begin
    if (reset) begin
      Ra1E <= '0;
      Ra2E <= '0;
      WA3E <= '0;
      WA3M <= '0;
      WA3W <= '0;
    end else begin
      if (FlushE) begin
        Ra1E <= '0;
        Ra2E <= '0;
        WA3E <= '0;
      end else begin
        Ra1E <= Ra1D;
        Ra2E <= Ra2D;
        WA3E <= WA3D;
      end
      WA3M <= WA3E;
      WA3W <= WA3M;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Memory stage wins over writeback: it holds the younger result.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      if (RegWriteM && tag_match(WA3M, Ra1E))      ForwardAE = FWD_MEM;
      else if (RegWriteW && tag_match(WA3W, Ra1E)) ForwardAE = FWD_WB;
      if (RegWriteM && tag_match(WA3M, Ra2E))      ForwardBE = FWD_MEM;
      else if (RegWriteW && tag_match(WA3W, Ra2E)) ForwardBE = FWD_WB;
    end
  end

  // Load data only exists after M, so a load-use pair cannot be forwarded.
  assign data_stall = MemtoRegE && RegWriteE &&
                      (tag_match(WA3E, Ra1D) || tag_match(WA3E, Ra2D));
`else
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
  end

  // Without forwarding, decode waits until the producer has reached W
  // (register file writes first half, reads second half).
  assign data_stall = (RegWriteE && (tag_match(WA3E, Ra1D) || tag_match(WA3E, Ra2D))) ||
                      (RegWriteM && (tag_match(WA3M, Ra1D) || tag_match(WA3M, Ra2D)));

  logic unused_nofwd;
  assign unused_nofwd = ^{MemtoRegE, RegWriteW, Ra1E, Ra2E, WA3W};
`endif

  assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

  assign StallD = data_stall;
  assign StallF = data_stall || pc_wr_pending;
  assign FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
  assign FlushE = data_stall || BranchTakenE;

  hazard_sat_counter #(.width(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallD),
    .count (StallCount)
  );

  hazard_sat_counter #(.width(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed scenarios plus random traffic for hazard_unit,
// checked against a behavioural model of the instruction tags.
// Honours HAZARD_FORWARDING_EN the same way the design does.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Ra1D, Ra2D, WA3D;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount, FlushCount;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .Ra1D         (Ra1D),
    .Ra2D         (Ra2D),
    .WA3D         (WA3D),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: which register each in-flight instruction reads/writes.
  logic [3:0] e_src1 = '0, e_src2 = '0, e_dst = '0, m_dst = '0, w_dst = '0;
  int         n_stall = 0, n_flush = 0;

  // Outputs captured at the last checked cycle.
  logic        s_stallf, s_stalld, s_flushd, s_flushe;
  logic [1:0]  s_fa, s_fb;
  logic [15:0] s_sc, s_fc;

  function automatic bit dep(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && (a != 4'd15);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Ra1D = '0; Ra2D = '0; WA3D = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cyc(input bit full);
    bit         stl, pcw, fle;
    logic [1:0] ea, eb;
    @(negedge clk);
`ifdef HAZARD_FORWARDING_EN
    stl = MemtoRegE && RegWriteE && (dep(e_dst, Ra1D) || dep(e_dst, Ra2D));
    ea = 2'b00;
    eb = 2'b00;
    if (!reset) begin
      if (RegWriteM && dep(m_dst, e_src1)) ea = 2'b10;
      else if (RegWriteW && dep(w_dst, e_src1)) ea = 2'b01;
      if (RegWriteM && dep(m_dst, e_src2)) eb = 2'b10;
      else if (RegWriteW && dep(w_dst, e_src2)) eb = 2'b01;
    end
`else
    stl = (RegWriteE && (dep(e_dst, Ra1D) || dep(e_dst, Ra2D))) ||
          (RegWriteM && (dep(m_dst, Ra1D) || dep(m_dst, Ra2D)));
    ea = 2'b00;
    eb = 2'b00;
`endif
    pcw = PCSrcD || PCSrcE || PCSrcM;
    fle = stl || BranchTakenE;
    s_stallf = StallF; s_stalld = StallD; s_flushd = FlushD; s_flushe = FlushE;
    s_fa = ForwardAE; s_fb = ForwardBE; s_sc = StallCount; s_fc = FlushCount;
    if (full) begin
      chk("StallF", StallF, stl || pcw);
      chk("StallD", StallD, stl);
      chk("FlushD", FlushD, pcw || PCSrcW || BranchTakenE);
      chk("FlushE", FlushE, fle);
      chk("ForwardAE", ForwardAE, ea);
      chk("ForwardBE", ForwardBE, eb);
      chk("StallCount", StallCount, n_stall[15:0]);
      chk("FlushCount", FlushCount, n_flush[15:0]);
    end
    @(posedge clk);
    if (reset) begin
      e_src1 = '0; e_src2 = '0; e_dst = '0; m_dst = '0; w_dst = '0;
      n_stall = 0; n_flush = 0;
    end else begin
      w_dst = m_dst;
      m_dst = e_dst;
      if (fle) begin
        e_src1 = '0; e_src2 = '0; e_dst = '0;
      end else begin
        e_src1 = Ra1D; e_src2 = Ra2D; e_dst = WA3D;
      end
      if (stl && n_stall < 65535) n_stall++;
      if (fle && n_flush < 65535) n_flush++;
    end
    #1;
  endtask

  initial begin
    int st, fd, sf, c0;
    clr();
    reset = 1;
    cyc(0);
    cyc(1);
    chk("rst_StallCount", s_sc, 16'h0000);
    chk("rst_FlushCount", s_fc, 16'h0000);
    chk("rst_ForwardAE", s_fa, 2'b00);
    reset = 0;

    // ADD r2 followed by a reader of r2
    clr(); WA3D = 4'd2; cyc(1);
    clr(); RegWriteE = 1; Ra1D = 4'd2; WA3D = 4'd5; cyc(1);
`ifdef HAZARD_FORWARDING_EN
    chk("add_nostall", s_stalld, 1'b0);
    clr(); RegWriteM = 1; RegWriteE = 1; cyc(1);
    chk("add_fwdA_mem", s_fa, 2'b10);
    chk("add_nostall2", s_stalld, 1'b0);
`else
    st = int'(s_stalld);
    clr(); RegWriteM = 1; Ra1D = 4'd2; WA3D = 4'd5; cyc(1);
    st += int'(s_stalld);
    clr(); RegWriteW = 1; Ra1D = 4'd2; WA3D = 4'd5; cyc(1);
    st += int'(s_stalld);
    chk("raw_stall_cycles", st[15:0], 16'd2);
`endif

    // LDR r3 followed by a reader of r3 on operand B
    clr(); WA3D = 4'd3; cyc(1);
    c0 = n_stall;
    clr(); MemtoRegE = 1; RegWriteE = 1; Ra2D = 4'd3; WA3D = 4'd6; cyc(1);
    chk("ldr_stallF", s_stallf, 1'b1);
    chk("ldr_stallD", s_stalld, 1'b1);
    chk("ldr_flushE", s_flushe, 1'b1);
    clr(); RegWriteM = 1; Ra2D = 4'd3; WA3D = 4'd6; cyc(1);
`ifdef HAZARD_FORWARDING_EN
    chk("ldr_one_cycle", s_stalld, 1'b0);
    chk("ldr_count", s_sc, 16'(c0 + 1));
    clr(); RegWriteW = 1; RegWriteE = 1; cyc(1);
    chk("ldr_fwdB_wb", s_fb, 2'b01);
`else
    clr(); RegWriteW = 1; Ra2D = 4'd3; WA3D = 4'd6; cyc(1);
`endif

    // Taken branch
    clr(); cyc(1);
    c0 = n_flush;
    clr(); BranchTakenE = 1; cyc(1);
    chk("br_flushD", s_flushd, 1'b1);
    chk("br_flushE", s_flushe, 1'b1);
    clr(); cyc(1);
    chk("br_flushD_off", s_flushd, 1'b0);
    chk("br_flushE_off", s_flushe, 1'b0);
    chk("br_count", s_fc, 16'(c0 + 1));

    // PC write travelling D -> E -> M -> W
    sf = 0; fd = 0;
    for (int k = 0; k < 5; k++) begin
      clr();
      PCSrcD = (k == 0); PCSrcE = (k == 1); PCSrcM = (k == 2); PCSrcW = (k == 3);
      cyc(1);
      sf += int'(s_stallf);
      fd += int'(s_flushd);
    end
    chk("pc_stallF_cycles", sf[15:0], 16'd3);
    chk("pc_flushD_cycles", fd[15:0], 16'd4);

    // r15 never creates a dependency
    clr(); WA3D = 4'd15; cyc(1);
    clr(); MemtoRegE = 1; RegWriteE = 1; Ra1D = 4'd15; cyc(1);
    chk("r15_nostall", s_stalld, 1'b0);
    clr(); RegWriteM = 1; cyc(1);
    chk("r15_nofwd", s_fa, 2'b00);

    // Load-use stall and taken branch in the same cycle
    clr(); WA3D = 4'd4; cyc(1);
    c0 = n_flush;
    clr(); MemtoRegE = 1; RegWriteE = 1; Ra1D = 4'd4; BranchTakenE = 1; cyc(1);
    chk("both_stallD", s_stalld, 1'b1);
    chk("both_flushE", s_flushe, 1'b1);
    chk("both_flushD", s_flushd, 1'b1);
    clr(); cyc(1);
    chk("both_flush_once", s_fc, 16'(c0 + 1));

    // Random traffic with a small address pool so dependencies are frequent
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      Ra1D = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      Ra2D = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      WA3D = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      PCSrcD = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
      PCSrcM = ($urandom_range(0, 5) == 0); PCSrcW = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      cyc(1);
    end

    // Counter saturation under a permanent stall, then reset
    clr(); reset = 1; cyc(1);
    reset = 0;
    RegWriteE = 1; MemtoRegE = 1;
    for (int i = 0; i < 70000; i++) cyc(0);
    cyc(1);
    chk("sat_stall_held", s_stalld, 1'b1);
    chk("sat_StallCount", s_sc, 16'hFFFF);
    chk("sat_FlushCount", s_fc, 16'hFFFF);
    reset = 1; BranchTakenE = 1; cyc(1);
    reset = 0; clr(); cyc(1);
    chk("post_rst_StallCount", s_sc, 16'h0000);
    chk("post_rst_FlushCount", s_fc, 16'h0000);
    chk("post_rst_ForwardBE", s_fb, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Ra1D, Ra2D  input  4 each  decode-stage source register addresses.
REQ-004 WA3D  input  4  decode-stage destination register address.
REQ-005 RegWriteE, RegWriteM, RegWriteW  input  1 each  per-stage register-write enables, already condition-gated in M and W.
REQ-006 MemtoRegE  input  1  execute-stage instruction is a load.
REQ-007 PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1 each  per-stage PC-write pending flags.
REQ-008 BranchTakenE  input  1  branch resolved taken in execute.
REQ-009 StallF, StallD  output  1 each  hold the fetch and decode pipeline registers.
REQ-010 FlushD, FlushE  output  1 each  clear the decode and execute pipeline registers.
REQ-011 ForwardAE, ForwardBE  output  2 each  operand-A and operand-B source select for execute.
REQ-012 StallCount, FlushCount  output  16 each  saturating event counters.

Function
REQ-013 Internal tag pipeline: Ra1E, Ra2E and WA3E are loaded from Ra1D, Ra2D and WA3D each cycle; WA3M is loaded from WA3E; WA3W is loaded from WA3M.
REQ-014 When FlushE=1, Ra1E, Ra2E and WA3E load 0 instead of the decode values; the M and W tags always advance.
REQ-015 Register 15 never matches: any compare against address 4'hF is treated as false.
REQ-016 Forward encoding for operand A: ForwardAE=2'b10 if RegWriteM and WA3M==Ra1E; otherwise 2'b01 if RegWriteW and WA3W==Ra1E; otherwise 2'b00 (register file).
REQ-017 ForwardBE follows the same rule as REQ-016 with Ra2E; M has priority over W when both match.
REQ-018 LDRstall = MemtoRegE & RegWriteE & (WA3E==Ra1D | WA3E==Ra2D).
REQ-019 PCWrPending = PCSrcD | PCSrcE | PCSrcM.
REQ-020 StallD = LDRstall.
REQ-021 StallF = LDRstall | PCWrPending.
REQ-022 FlushD = PCWrPending | PCSrcW | BranchTakenE.
REQ-023 FlushE = LDRstall | BranchTakenE.
REQ-024 All outputs other than the counters are combinational from the inputs and tags, with zero-cycle latency.
REQ-025 StallCount increments by 1 each cycle StallD=1; FlushCount increments by 1 each cycle FlushE=1; both saturate at 16'hFFFF with no wrap.
REQ-026 Simultaneous LDRstall and BranchTakenE: StallD=1, FlushE=1 and FlushD=1; FlushCount increments once for the cycle.

Reset
REQ-027 While reset=1, all tags load 4'h0, StallCount=0 and FlushCount=0, and both Forward outputs read 2'b00.
REQ-028 An asserted reset overrides a concurrent flush or count event; the first cycle after reset sees all tags at 0.

Configuration
REQ-029 Macro HAZARD_FORWARDING_EN selects the forwarding feature.
REQ-030 With HAZARD_FORWARDING_EN defined, REQ-016 to REQ-018 apply as written.
REQ-031 Without HAZARD_FORWARDING_EN:
- ForwardAE and ForwardBE are tied to 2'b00.
- LDRstall is replaced by RAWstall = any match of Ra1D or Ra2D against (RegWriteE & WA3E) or (RegWriteM & WA3M).
- RAWstall drives StallD, StallF and FlushE wherever LDRstall appears in REQ-020 to REQ-023.

Structure
REQ-032 The shared package hazard_pkg holds:
- forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
- the constant REG_PC=4'hF;
- the counter width parameter CNT_W=16.
REQ-033 Both counters are instances of one sub-module, hazard_sat_counter, with parameter width, inputs clk, reset and inc, and output count.

Verification
REQ-034 Scenario: ADD writes r2 in M, next instruction reads r2 in E -> ForwardAE=2'b10, no stall.
REQ-035 Scenario: LDR r3 in E, decode reads r3 (Ra2D=3) -> StallF=StallD=FlushE=1 for exactly 1 cycle; the next cycle gives ForwardBE=2'b01, and StallCount goes from 0 to 1.
REQ-036 Scenario: BranchTakenE=1 -> FlushD=FlushE=1 in that cycle only, and FlushCount increments.
REQ-037 Scenario: PCSrcD=1 then advances through E, M and W -> StallF=1 for 3 cycles and FlushD=1 for 4 cycles.
REQ-038 Scenario: Ra1D=WA3E=15 with MemtoRegE=1 -> no stall; ForwardAE stays 2'b00.
REQ-039 Scenario: StallD forced high for 70000 cycles -> StallCount=16'hFFFF and holds; reset then gives 0 on the next edge; a build without HAZARD_FORWARDING_EN gives a 2-cycle stall for the REQ-034 case.
